multicycle_ctrl_fsm: RTL and testbench

Sequencer for the multi-cycle RV32I datapath. It steps each instruction through the FETCH, DECODE, EXEC, MEM and WB states, drives the per-cycle datapath enables, and handshakes with the shared instruction/data memory port. Illegal opcodes and memory timeouts go to an absorbing TRAP state. It sits between the instruction register / ALU compare output and the datapath muxes, register file and memory port.

---
 rtl/multicycle_ctrl_fsm_if.sv | 21 ++
 rtl/multicycle_ctrl_fsm.sv | 179 +++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_if.sv
// rtl/multicycle_ctrl_fsm_if.sv - shared instruction/data memory port handshake
interface multicycle_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_is_instr;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_is_instr,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_is_instr,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - RV32I multi-cycle sequencer with memory handshake and trap state
module multicycle_ctrl_fsm #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_ctrl_fsm_if.master mem,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic                 alu_src,
  output logic [1:0]           alu_src_a,
  output logic [2:0]           state,
  output logic                 illegal_instr,
  output logic                 bus_timeout,
  output logic                 instr_retired,
  output logic [CNT_W-1:0]     retired_cnt
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state_next;
  logic [6:0]  op_q;
  logic [15:0] wait_cnt;
  logic        opcode_legal;
  logic        wait_expired;
  logic        set_illegal;
  logic        set_timeout;

  logic       req_c, we_c, is_instr_c, ir_write_c, pc_write_c, pc_src_c;
  logic       reg_write_c, alu_src_c, retired_c;
  logic [1:0] result_src_c, alu_src_a_c;

  always_comb begin
    case (opcode)
      OP_LOAD, OP_STORE, OP_BRANCH, OP_R, OP_I, OP_JAL, OP_JALR: opcode_legal = 1'b1;
      default:                                                  opcode_legal = 1'b0;
    endcase
  end

  assign wait_expired = (wait_cnt == WAIT_LAST);

  always_comb begin
    state_next   = state;
    req_c        = 1'b0;
    we_c         = 1'b0;
    is_instr_c   = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = 1'b0;
    reg_write_c  = 1'b0;
    result_src_c = 2'b00;
    alu_src_c    = 1'b0;
    alu_src_a_c  = 2'b00;
    retired_c    = 1'b0;
    set_illegal  = 1'b0;
    set_timeout  = 1'b0;
    case (state)
      S_FETCH: begin
        req_c      = 1'b1;
        is_instr_c = 1'b1;
        if (mem.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_next = S_DECODE;
        end else if (wait_expired) begin
          set_timeout = 1'b1;
          state_next  = S_TRAP;
        end
      end
      S_DECODE: begin
        if (opcode_legal) begin
          state_next = S_EXEC;
        end else begin
          set_illegal = 1'b1;
          state_next  = S_TRAP;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_R:              state_next = S_WB;
          OP_I: begin
            alu_src_c  = 1'b1;
            state_next = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_c  = 1'b1;
            state_next = S_MEM;
          end
          OP_BRANCH: begin
            pc_write_c = branch_taken;
            pc_src_c   = 1'b1;
            retired_c  = 1'b1;
            state_next = S_FETCH;
          end
          OP_JAL, OP_JALR: begin
            alu_src_a_c = (op_q == OP_JAL) ? 2'b01 : 2'b00;
            alu_src_c   = 1'b1;
            pc_write_c  = 1'b1;
            pc_src_c    = 1'b1;
            state_next  = S_WB;
          end
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        req_c = 1'b1;
        we_c  = (op_q == OP_STORE);
        if (mem.mem_ready) begin
          retired_c  = (op_q == OP_STORE);
          state_next = (op_q == OP_STORE) ? S_FETCH : S_WB;
        end else if (wait_expired) begin
          set_timeout = 1'b1;
          state_next  = S_TRAP;
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        result_src_c = (op_q == OP_LOAD) ? 2'b01 :
                       (op_q == OP_JAL || op_q == OP_JALR) ? 2'b10 : 2'b00;
        retired_c    = 1'b1;
        state_next   = S_FETCH;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_TRAP;
    endcase
  end

  // A cycle with rst high must not disturb memory or architectural state.
  assign mem.mem_req      = req_c & ~rst;
  assign mem.mem_we       = we_c & ~rst;
  assign mem.mem_is_instr = is_instr_c & ~rst;
  assign ir_write         = ir_write_c & ~rst;
  assign pc_write         = pc_write_c & ~rst;
  assign pc_src           = pc_src_c & ~rst;
  assign reg_write        = reg_write_c & ~rst;
  assign result_src       = rst ? 2'b00 : result_src_c;
  assign alu_src          = alu_src_c & ~rst;
  assign alu_src_a        = rst ? 2'b00 : alu_src_a_c;
  assign instr_retired    = retired_c & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_FETCH;
      wait_cnt      <= 16'd0;
      op_q          <= 7'd0;
      retired_cnt   <= '0;
      illegal_instr <= 1'b0;
      bus_timeout   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) op_q <= opcode;
      if (state_next != state) wait_cnt <= 16'd0;
      else if (req_c && !mem.mem_ready) wait_cnt <= wait_cnt + 16'd1;
      if (set_illegal) illegal_instr <= 1'b1;
      if (set_timeout) bus_timeout <= 1'b1;
      if (retired_c) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - randomized trace-level check of the multi-cycle sequencer
module tb_multicycle_ctrl_fsm;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             ir_write, pc_write, pc_src, reg_write, alu_src, illegal_instr, bus_timeout, instr_retired;
  logic [1:0]       result_src, alu_src_a;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired_cnt;
  logic [12:0]      got_ctl;

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mem(bus), .opcode(opcode), .branch_taken(branch_taken),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .result_src(result_src), .alu_src(alu_src), .alu_src_a(alu_src_a), .state(state),
    .illegal_instr(illegal_instr), .bus_timeout(bus_timeout), .instr_retired(instr_retired),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  assign got_ctl = {bus.mem_req, bus.mem_we, bus.mem_is_instr, ir_write, pc_write, pc_src,
                    reg_write, result_src, alu_src, alu_src_a, instr_retired};

  typedef struct {
    logic       r;
    logic [2:0] st;
    logic       rdy;
    logic       bt;
    logic [6:0] op;
    logic [12:0] ctl;
    logic [1:0] flags;
  } cyc_t;

  cyc_t       trace_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         model_cnt = 0;
  logic [6:0] legal_ops [7] = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_R, OP_I, OP_JAL, OP_JALR};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [12:0] ctl(input logic req, we, ins, irw, pcw, pcs, rw,
                                      input logic [1:0] rs, input logic as,
                                      input logic [1:0] asa, input logic ret);
    return {req, we, ins, irw, pcw, pcs, rw, rs, as, asa, ret};
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_BRANCH, OP_R, OP_I, OP_JAL, OP_JALR};
  endfunction

  task automatic push(input logic r, input logic [2:0] st, input logic rdy, input logic bt,
                      input logic [6:0] op, input logic [12:0] c, input logic [1:0] flags);
    cyc_t e;
    e.r = r; e.st = st; e.rdy = rdy; e.bt = bt; e.op = op; e.ctl = c; e.flags = flags;
    trace_q.push_back(e);
  endtask

  // Cycle where only state and outputs matter; the other inputs are noise.
  task automatic push_s(input logic [2:0] st, input logic rdy, input logic [12:0] c);
    push(1'b0, st, rdy, 1'($urandom), 7'($urandom), c, 2'b00);
  endtask

  task automatic trap_then_reset(input logic [1:0] flags);
    int n = 4 + $urandom_range(16);
    for (int i = 0; i < n; i++) push(1'b0, S_T, 1'($urandom), 1'($urandom), 7'($urandom), 13'd0, flags);
    push(1'b1, S_T, 1'($urandom), 1'($urandom), 7'($urandom), 13'd0, flags);
  endtask

  // Expected cycle-by-cycle trace of one instruction from FETCH entry.
  task automatic build_instr(input logic [6:0] op, input int fw, input int mw,
                             input logic bt, input bit abort_mem);
    logic       we = (op == OP_STORE);
    logic [1:0] rs;
    for (int i = 0; i < fw; i++) begin
      push_s(S_F, 1'b0, ctl(1,0,1,0,0,0,0,2'b00,0,2'b00,0));
      if (i == TIMEOUT - 1) begin trap_then_reset(2'b01); return; end
    end
    push_s(S_F, 1'b1, ctl(1,0,1,1,1,0,0,2'b00,0,2'b00,0));
    push(1'b0, S_D, 1'($urandom), 1'($urandom), op, 13'd0, 2'b00);
    if (!is_legal(op)) begin trap_then_reset(2'b10); return; end
    case (op)
      OP_BRANCH: begin
        push(1'b0, S_E, 1'($urandom), bt, 7'($urandom), ctl(0,0,0,0,bt,1,0,2'b00,0,2'b00,1), 2'b00);
        return;
      end
      OP_R:    push_s(S_E, 1'($urandom), ctl(0,0,0,0,0,0,0,2'b00,0,2'b00,0));
      OP_JAL:  push_s(S_E, 1'($urandom), ctl(0,0,0,0,1,1,0,2'b00,1,2'b01,0));
      OP_JALR: push_s(S_E, 1'($urandom), ctl(0,0,0,0,1,1,0,2'b00,1,2'b00,0));
      default: push_s(S_E, 1'($urandom), ctl(0,0,0,0,0,0,0,2'b00,1,2'b00,0));
    endcase
    if (op == OP_LOAD || op == OP_STORE) begin
      for (int i = 0; i < mw; i++) begin
        push_s(S_M, 1'b0, ctl(1,we,0,0,0,0,0,2'b00,0,2'b00,0));
        if (abort_mem) begin
          push(1'b1, S_M, 1'b1, 1'($urandom), 7'($urandom), 13'd0, 2'b00);
          return;
        end
        if (i == TIMEOUT - 1) begin trap_then_reset(2'b01); return; end
      end
      push_s(S_M, 1'b1, ctl(1,we,0,0,0,0,0,2'b00,0,2'b00,we));
      if (we) return;
    end
    rs = (op == OP_LOAD) ? 2'b01 : (op == OP_JAL || op == OP_JALR) ? 2'b10 : 2'b00;
    push_s(S_W, 1'($urandom), ctl(0,0,0,0,0,0,1,rs,0,2'b00,1));
  endtask

  task automatic play();
    while (trace_q.size() > 0) begin
      cyc_t e = trace_q.pop_front();
      rst = e.r; bus.mem_ready = e.rdy; branch_taken = e.bt; opcode = e.op;
      @(negedge clk);
      check("state", 32'(state), 32'(e.st));
      check("ctl", 32'(got_ctl), 32'(e.ctl));
      check("flags", 32'({illegal_instr, bus_timeout}), 32'(e.flags));
      check("retired_cnt", 32'(retired_cnt), 32'(model_cnt % (1 << CNT_W)));
      @(posedge clk); #1;
      if (e.r) model_cnt = 0;
      else if (e.ctl[0]) model_cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus.mem_ready = 1'b0; branch_taken = 1'b0; opcode = 7'd0;
    @(posedge clk); #1;
    push(1'b1, S_F, 1'b1, 1'b0, 7'd0, 13'd0, 2'b00);
    play();

    build_instr(OP_R, 0, 0, 1'b0, 0);      play();
    build_instr(OP_LOAD, 2, 0, 1'b0, 0);   play();
    build_instr(OP_STORE, 0, 0, 1'b0, 0);  play();
    build_instr(OP_BRANCH, 0, 0, 1'b1, 0); play();
    build_instr(OP_BRANCH, 0, 0, 1'b0, 0); play();
    build_instr(OP_JAL, 0, 0, 1'b0, 0);    play();
    build_instr(OP_JALR, 1, 0, 1'b0, 0);   play();
    build_instr(7'b1111111, 0, 0, 1'b0, 0); play();
    build_instr(OP_R, TIMEOUT, 0, 1'b0, 0); play();
    build_instr(OP_LOAD, 0, 2, 1'b0, 1);   play();
    build_instr(OP_STORE, 0, TIMEOUT, 1'b0, 0); play();
    for (int n = 0; n < 20; n++) begin
      build_instr(OP_I, 0, 0, 1'b0, 0);
      play();
    end

    for (int n = 0; n < 80; n++) begin
      logic [6:0] op;
      int fw, mw;
      if ($urandom_range(15) == 0) begin
        do op = 7'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(6)];
      end
      fw = ($urandom_range(15) == 0) ? TIMEOUT : int'($urandom_range(2));
      mw = ($urandom_range(15) == 0) ? TIMEOUT : int'($urandom_range(TIMEOUT - 1));
      build_instr(op, fw, mw, 1'($urandom), 0);
      play();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
